// File: rtl/upd_vec_pkg.sv
// Shared types, default parameters and elaboration helpers for the update-vector generator.
package upd_vec_pkg;

  localparam int LFSR_W_DEF  = 15;
  localparam int VEC_W_DEF   = 3;
  localparam int RX_DEF      = 3;
  localparam int RY_DEF      = 2;
  localparam int NUM_CH_DEF  = 2;
  localparam int MAX_TRY_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } upd_state_e;

  // Fibonacci tap masks: bit k set means stage k+1 feeds the XOR.
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      17:      return 32'h0001_2000;
      default: return (32'd1 << (w - 1)) | (32'd1 << (w - 2));
    endcase
  endfunction

  function automatic int tbl_n(input int rx, input int ry);
    return (2 * rx + 1) * (2 * ry + 1) - 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/upd_lfsr.sv
// Fibonacci LFSR with synchronous seed load; exposes its low OUT_W stages as a table index.
module upd_lfsr
  import upd_vec_pkg::*;
#(
  parameter int LFSR_W = LFSR_W_DEF,
  parameter int OUT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [OUT_W-1:0]  idx
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] lfsr;
  logic              fb;

  assign fb  = ^(lfsr & TAPS);
  assign idx = lfsr[OUT_W-1:0];

  // All-zero is the lock-up state, so a zero seed is replaced by 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_W'(1);
    end else if (load) begin
      lfsr <= (load_val == '0) ? LFSR_W'(1) : load_val;
    end else if (adv) begin
      lfsr <= {lfsr[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/upd_vec_gen.sv
// Draws NUM_CH distinct (x,y) update vectors from an LFSR-indexed table of all non-zero vectors.
// Defining UPD_SEED_LOAD_EN adds the seed_ld/seed ports for reseeding (and aborting) at run time.
//   state | meaning
//   IDLE  | waiting for req; LFSR free-runs while en=1
//   DRAW  | one candidate per cycle until every channel is stored
//   DONE  | valid pulse; uvec/fallback hold the new set
module upd_vec_gen
  import upd_vec_pkg::*;
#(
  parameter int LFSR_W  = LFSR_W_DEF,
  parameter int VEC_W   = VEC_W_DEF,
  parameter int RX      = RX_DEF,
  parameter int RY      = RY_DEF,
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int MAX_TRY = MAX_TRY_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      req,
`ifdef UPD_SEED_LOAD_EN
  input  logic                      seed_ld,
  input  logic [LFSR_W-1:0]         seed,
`endif
  output logic                      busy,
  output logic                      valid,
  output logic [NUM_CH*2*VEC_W-1:0] uvec,
  output logic                      fallback
);

  localparam int N     = tbl_n(RX, RY);
  localparam int IDX_W = idx_w(N);
  localparam int EW    = 2 * VEC_W;
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW    = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

  if (RX > 2**(VEC_W-1) - 1 || RY > 2**(VEC_W-1) - 1 || NUM_CH > N || LFSR_W < IDX_W) begin : g_cfg_err
    $error("upd_vec_gen: unsupported parameter combination");
  end

  function automatic logic [N*EW-1:0] build_tbl();
    logic [N*EW-1:0] t;
    int              k;
    t = '0;
    k = 0;
    for (int x = -RX; x <= RX; x++) begin
      for (int y = -RY; y <= RY; y++) begin
        if (x != 0 || y != 0) begin
          t[k*EW +: EW] = {VEC_W'(y), VEC_W'(x)};
          k++;
        end
      end
    end
    return t;
  endfunction

  localparam logic [N*EW-1:0] TBL = build_tbl();

  upd_state_e           state;
  logic [IDX_W-1:0]     cand_idx;
  logic [IDX_W-1:0]     cand_sel;
  logic                 cand_in;
  logic                 cand_ok;
  logic [EW-1:0]        cand;
  logic [EW-1:0]        fb_ent;
  logic                 fb_hit;
  logic [EW-1:0]        store_val;
  logic [NUM_CH*EW-1:0] next_vec;
  logic [CW-1:0]        ch_cnt;
  logic [TW-1:0]        try_cnt;
  logic [EW-1:0]        ch_q [NUM_CH];
  logic                 try_last;
  logic                 lfsr_adv;
  logic                 seed_abort;
  logic [LFSR_W-1:0]    seed_val;

`ifdef UPD_SEED_LOAD_EN
  assign seed_abort = seed_ld;
  assign seed_val   = seed;
`else
  assign seed_abort = 1'b0;
  assign seed_val   = '0;
`endif

  assign lfsr_adv = en || (state == ST_DRAW);

  upd_lfsr #(.LFSR_W(LFSR_W), .OUT_W(IDX_W)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .adv      (lfsr_adv),
    .load     (seed_abort),
    .load_val (seed_val),
    .idx      (cand_idx)
  );

  assign cand_in  = int'(cand_idx) < N;
  assign cand_sel = cand_in ? cand_idx : '0;
  assign cand     = TBL[int'(cand_sel)*EW +: EW];
  assign try_last = (try_cnt == TW'(MAX_TRY - 1));

  always_comb begin
    cand_ok = cand_in;
    for (int c = 0; c < NUM_CH; c++) begin
      if (c < int'(ch_cnt) && ch_q[c] == cand) cand_ok = 1'b0;
    end
  end

  // At most NUM_CH-1 channels are stored, so one of the first NUM_CH entries is always free.
  always_comb begin
    fb_ent = TBL[0 +: EW];
    fb_hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      fb_hit = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (c < int'(ch_cnt) && ch_q[c] == TBL[i*EW +: EW]) fb_hit = 1'b1;
      end
      if (!fb_hit) fb_ent = TBL[i*EW +: EW];
    end
  end

  assign store_val = cand_ok ? cand : fb_ent;

  always_comb begin
    next_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      next_vec[c*EW +: EW] = (c == int'(ch_cnt)) ? store_val : ch_q[c];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      fallback <= 1'b0;
      uvec     <= '0;
      ch_cnt   <= '0;
      try_cnt  <= '0;
      for (int c = 0; c < NUM_CH; c++) ch_q[c] <= '0;
    end else if (seed_abort) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state    <= ST_DRAW;
            busy     <= 1'b1;
            fallback <= 1'b0;
            ch_cnt   <= '0;
            try_cnt  <= '0;
          end
        end
        ST_DRAW: begin
          if (cand_ok || try_last) begin
            ch_q[ch_cnt] <= store_val;
            try_cnt      <= '0;
            if (!cand_ok) fallback <= 1'b1;
            if (ch_cnt == CW'(NUM_CH - 1)) begin
              state <= ST_DONE;
              valid <= 1'b1;
              uvec  <= next_vec;
            end else begin
              ch_cnt <= ch_cnt + CW'(1);
            end
          end else begin
            try_cnt <= try_cnt + TW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
